// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave front end for the on-chip sram: decodes the address phase into sram strobes,
// stalls the data phase until the sram ready pulse, and returns OKAY/ERROR responses.
module ahb_sram_bridge #(
  parameter int unsigned ADDR_BITS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [1:0]  mem_trans,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_bl,
  output logic        mem_we,
  output logic        mem_ce,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccess = 3'd1;
  localparam logic [2:0] StDone   = 3'd2;
  localparam logic [2:0] StErr1   = 3'd3;
  localparam logic [2:0] StErr2   = 3'd4;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      bl_q, bl_d;
  logic [1:0]      trans_q, trans_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hrdata_q, hrdata_d;

  logic        can_accept, accept, legal;
  logic [3:0]  lanes;
  logic [31:0] addr_masked;
  logic        unused_haddr;

  assign unused_haddr = ^haddr;

  always_comb begin
    addr_masked                  = '0;
    addr_masked[ADDR_BITS-1:0]   = haddr[ADDR_BITS-1:0];
  end

  assign can_accept = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
  assign accept     = hsel & htrans[1] & hready & can_accept;

  always_comb begin
    lanes = 4'b0000;
    legal = 1'b0;
    case (hsize)
      3'd0: begin
        lanes = 4'b0001 << haddr[1:0];
        legal = 1'b1;
      end
      3'd1: begin
        lanes = haddr[1] ? 4'b1100 : 4'b0011;
        legal = ~haddr[0];
      end
      3'd2: begin
        lanes = 4'b1111;
        legal = (haddr[1:0] == 2'b00);
      end
      default: begin
        lanes = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hwrite_d = hwrite_q;
    addr_d   = addr_q;
    bl_d     = bl_q;
    trans_d  = trans_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    case (state_q)
      StIdle, StDone, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (legal) begin
            // Memory-facing registers only move for accesses that actually reach the sram
            hwrite_d = hwrite;
            addr_d   = addr_masked;
            bl_d     = lanes;
            trans_d  = htrans;
            cnt_d    = '0;
            state_d  = StAccess;
          end else begin
            state_d = StErr1;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d = StDone;
          if (!hwrite_q) hrdata_d = mem_read_data;
        end else if (TimeoutEn && (cnt_q == CntMax)) begin
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      hwrite_q <= 1'b0;
      addr_q   <= '0;
      bl_q     <= '0;
      trans_q  <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      hwrite_q <= hwrite_d;
      addr_q   <= addr_d;
      bl_q     <= bl_d;
      trans_q  <= trans_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign mem_ce         = (state_q == StAccess);
  assign mem_we         = mem_ce & hwrite_q;
  assign mem_write_data = mem_ce ? hwdata : '0;
  assign mem_address    = addr_q;
  assign mem_bl         = bl_q;
  assign mem_trans      = trans_q;
  assign hreadyout      = ~((state_q == StAccess) || (state_q == StErr1));
  assign hresp          = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
  assign hrdata         = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Randomized bench for ahb_sram_bridge: a transaction-level model produces the expected bus and
// sram waveforms cycle by cycle, and a behavioural sram with variable wait states answers requests.
module tb_ahb_sram_bridge;

  localparam int Tmo = 4;

  logic        hclk;
  logic        hresetn;
  logic        hsel, hwrite, hready, hreadyout, mem_we, mem_ce, mem_ready;
  logic [1:0]  htrans, hresp, mem_trans;
  logic [2:0]  hsize;
  logic [3:0]  mem_bl;
  logic [31:0] haddr, hwdata, hrdata, mem_address, mem_write_data, mem_read_data;
  logic        stall;

  assign hready = hreadyout & ~stall;

  ahb_sram_bridge #(
    .ADDR_BITS      (16),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .hsel           (hsel),
    .htrans         (htrans),
    .haddr          (haddr),
    .hwrite         (hwrite),
    .hsize          (hsize),
    .hwdata         (hwdata),
    .hready         (hready),
    .hreadyout      (hreadyout),
    .hresp          (hresp),
    .hrdata         (hrdata),
    .mem_trans      (mem_trans),
    .mem_address    (mem_address),
    .mem_bl         (mem_bl),
    .mem_we         (mem_we),
    .mem_ce         (mem_ce),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected waveform, set by the transaction driver from the model
  bit          chk_en = 0;
  bit          exp_rdy, exp_ce, exp_we, exp_rst;
  logic [1:0]  exp_resp, exp_trans;
  logic [3:0]  exp_bl;
  logic [31:0] exp_addr, exp_wdata, exp_hrdata;

  logic [31:0] ref_mem [64];
  logic [31:0] sram_mem [64];
  int          sram_wait = 0;
  bit          inject = 0;
  int          ce_cnt = 0;

  int          ce_run = 0, last_ce_len = 0, ce_total = 0;
  logic [3:0]  seen_bl = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      chk("hreadyout", 32'(hreadyout), 32'(exp_rdy));
      chk("hresp", 32'(hresp), 32'(exp_resp));
      chk("hrdata", hrdata, exp_hrdata);
      chk("mem_ce", 32'(mem_ce), 32'(exp_ce));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_ce) begin
        chk("mem_bl", 32'(mem_bl), 32'(exp_bl));
        chk("mem_address", mem_address, exp_addr);
        chk("mem_trans", 32'(mem_trans), 32'(exp_trans));
        chk("mem_write_data", mem_write_data, exp_wdata);
      end
      if (exp_rst) begin
        chk("rst mem_bl", 32'(mem_bl), 32'h0);
        chk("rst mem_address", mem_address, 32'h0);
        chk("rst mem_trans", 32'(mem_trans), 32'h0);
      end
    end
    if (mem_ce) begin
      ce_run++;
      ce_total++;
      seen_bl = mem_bl;
    end else if (ce_run != 0) begin
      last_ce_len = ce_run;
      ce_run = 0;
    end
  end

  // Behavioural sram: ready pulse after sram_wait extra cycles of chip enable
  initial begin
    mem_ready = 1'b0;
    mem_read_data = '0;
    forever begin
      @(posedge hclk);
      #2;
      if (mem_ce) begin
        ce_cnt++;
        if (ce_cnt == sram_wait + 1) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_bl[b]) sram_mem[mem_address[7:2]][8*b +: 8] = mem_write_data[8*b +: 8];
            mem_read_data = $urandom;
          end else begin
            mem_read_data = sram_mem[mem_address[7:2]];
          end
        end else begin
          mem_ready = 1'b0;
          mem_read_data = $urandom;
        end
      end else begin
        ce_cnt = 0;
        mem_ready = inject;
        mem_read_data = $urandom;
      end
    end
  end

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (s == 3'd0) return 1'b1;
    if (s == 3'd1) return (a % 2) == 0;
    if (s == 3'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [2:0] s);
    int off = int'(a % 4);
    if (s == 3'd0) return 4'(1 << off);
    if (s == 3'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
    inject = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_exp(input bit rdy, input logic [1:0] resp, input bit ce);
    exp_rdy  = rdy;
    exp_resp = resp;
    exp_ce   = ce;
    exp_we   = 1'b0;
    exp_rst  = 1'b0;
  endtask

  task automatic set_rst_exp();
    set_exp(1'b1, 2'b00, 1'b0);
    exp_rst    = 1'b1;
    exp_hrdata = '0;
  endtask

  task automatic idle();
    int pat = $urandom_range(0, 2);
    hsel   = (pat != 0);
    htrans = (pat == 2) ? 2'(($urandom_range(2, 3))) : 2'(($urandom_range(0, 1)));
    if (pat == 0) htrans = 2'($urandom);
    stall  = (pat == 2);
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
    hwdata = $urandom;
    step();
    stall = 1'b0;
    set_exp(1'b1, 2'b00, 1'b0);
  endtask

  // Drives one transfer whose address phase is the current cycle; returns in its final cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] data, input int wt);
    logic [1:0] tr;
    bit         legal, timed;
    logic [3:0] bl;
    int         n;
    tr    = 2'($urandom_range(2, 3));
    legal = is_legal(addr, size);
    bl    = lanes_of(addr, size);
    hsel = 1'b1; htrans = tr; haddr = addr; hwrite = wr; hsize = size; stall = 1'b0;
    sram_wait = wt;
    step();
    hwdata = wr ? data : $urandom;
    hsel   = 1'($urandom);
    htrans = 2'($urandom);
    haddr  = $urandom;
    if (legal) begin
      timed = (Tmo != 0) && (wt + 1 > Tmo);
      n     = timed ? Tmo : wt + 1;
      for (int i = 0; i < n; i++) begin
        set_exp(1'b0, 2'b00, 1'b1);
        exp_we    = wr;
        exp_bl    = bl;
        exp_addr  = {16'h0, addr[15:0]};
        exp_trans = tr;
        exp_wdata = hwdata;
        if (i < n - 1) step();
      end
      step();
      if (timed) begin
        set_exp(1'b0, 2'b01, 1'b0);
        step();
        set_exp(1'b1, 2'b01, 1'b0);
      end else begin
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (bl[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
        end else begin
          exp_hrdata = ref_mem[addr[7:2]];
        end
        set_exp(1'b1, 2'b00, 1'b0);
      end
    end else begin
      set_exp(1'b0, 2'b01, 1'b0);
      step();
      set_exp(1'b1, 2'b01, 1'b0);
    end
    hsel = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    int c0;
    logic [31:0] a;
    logic [2:0]  s;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = '0;
    end
    hresetn = 1'b1; hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0; hwdata = 0;
    stall = 0;
    #1;
    hresetn = 1'b0;
    set_rst_exp();
    chk_en = 1'b1;
    step();
    step();
    hresetn = 1'b1;
    idle();

    // Word write then read back
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
    chk("t1 write bl", 32'(seen_bl), 32'hF);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 0);
    chk("t1 read hrdata", hrdata, 32'hDEADBEEF);
    chk("t1 read bl", 32'(seen_bl), 32'hF);
    idle();

    // Sub-word lanes
    xfer(1'b1, 32'h13, 3'd0, 32'hAA5A5A5A, 1);
    chk("t2 byte bl", 32'(seen_bl), 32'h8);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 0);
    chk("t2 byte readback", hrdata, 32'hAAADBEEF);
    idle();
    xfer(1'b1, 32'h12, 3'd1, 32'h12347777, 2);
    chk("t2 half bl", 32'(seen_bl), 32'hC);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 0);
    chk("t2 half readback", hrdata, 32'h1234BEEF);
    idle();

    // Misaligned word read
    c0 = ce_total;
    xfer(1'b0, 32'h02, 3'd2, 32'h0, 0);
    chk("t3 err2 hreadyout", 32'(hreadyout), 32'h1);
    chk("t3 err2 hresp", 32'(hresp), 32'h1);
    idle();
    chk("t3 no mem_ce", 32'(ce_total - c0), 32'h0);

    // Timeout, stray ready in ERR2, then ready on the limit cycle
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 100);
    inject = 1'b1;
    chk("t4 ce length", 32'(last_ce_len), 32'(Tmo));
    idle();
    xfer(1'b0, 32'h10, 3'd2, 32'h0, Tmo - 1);
    idle();
    chk("t4 limit ce length", 32'(last_ce_len), 32'(Tmo));
    chk("t4 limit hrdata", hrdata, 32'h1234BEEF);

    // Back-to-back pipelined transfers
    xfer(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1);
    xfer(1'b0, 32'h24, 3'd2, 32'h0, 0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 0);
    chk("t5 readback", hrdata, 32'hCAFEF00D);
    idle();

    // Reset in the middle of an access
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h48; hwrite = 1'b0; hsize = 3'd2;
    sram_wait = 3;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      set_exp(1'b0, 2'b00, 1'b1);
      exp_bl = 4'hF; exp_addr = 32'h48; exp_trans = 2'b10; exp_wdata = hwdata;
      if (i < 2) step();
    end
    #2;
    hresetn = 1'b0;
    set_rst_exp();
    step();
    step();
    hresetn = 1'b1;
    idle();
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 2);
    chk("t6 fresh read", hrdata, 32'h1234BEEF);
    idle();

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      a = $urandom;
      s = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 3'd1) a[0] = 1'b0;
        if (s == 3'd2) a[1:0] = 2'b00;
      end
      xfer(1'($urandom), a, s, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 2)) idle();
      end
    end
    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
